// File: rtl/c5_alu_unit.sv
// c5 execute-stage ALU: add/sub/slt/sltu and bitwise logic on one shared 32-bit adder.
// Defining C5_ALU_OUTPUT_REG_EN adds a reset-able output register (1-cycle latency).
module c5_alu_unit (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [31:0] I_a_in,
    input  logic [31:0] I_b_in,
    input  logic [3:0]  I_alu_function,
    output logic [31:0] O_c_alu,
    output logic        O_zero,
    output logic        O_overflow
);

    localparam logic [3:0] FN_NOP  = 4'd0;
    localparam logic [3:0] FN_ADD  = 4'd1;
    localparam logic [3:0] FN_SUB  = 4'd2;
    localparam logic [3:0] FN_SLTU = 4'd3;
    localparam logic [3:0] FN_SLT  = 4'd4;
    localparam logic [3:0] FN_OR   = 4'd5;
    localparam logic [3:0] FN_AND  = 4'd6;
    localparam logic [3:0] FN_XOR  = 4'd7;
    localparam logic [3:0] FN_NOR  = 4'd8;

    logic        w_do_add;
    logic [31:0] w_b_op;
    logic [32:0] w_sum33;
    logic [31:0] w_sum;
    logic        w_carry;
    logic        w_ovf_add;
    logic        w_ovf_sub;
    logic [31:0] w_result;
    logic        w_overflow;
    logic        w_zero;

    // Everything except add runs the adder as A + ~B + 1, so compares reuse the subtract.
    assign w_do_add  = (I_alu_function == FN_ADD);
    assign w_b_op    = w_do_add ? I_b_in : ~I_b_in;
    assign w_sum33   = {1'b0, I_a_in} + {1'b0, w_b_op} + {32'd0, ~w_do_add};
    assign w_sum     = w_sum33[31:0];
    assign w_carry   = w_sum33[32];
    assign w_ovf_add = (I_a_in[31] == I_b_in[31]) && (w_sum[31] != I_a_in[31]);
    assign w_ovf_sub = (I_a_in[31] != I_b_in[31]) && (w_sum[31] != I_a_in[31]);

    always_comb begin
        w_result   = 32'd0;
        w_overflow = 1'b0;
        case (I_alu_function)
            FN_NOP:  w_result = 32'd0;
            FN_ADD:  begin
                w_result   = w_sum;
                w_overflow = w_ovf_add;
            end
            FN_SUB:  begin
                w_result   = w_sum;
                w_overflow = w_ovf_sub;
            end
            FN_SLTU: w_result = {31'd0, ~w_carry};
            FN_SLT:  w_result = {31'd0, w_sum[31] ^ w_ovf_sub};
            FN_OR:   w_result = I_a_in | I_b_in;
            FN_AND:  w_result = I_a_in & I_b_in;
            FN_XOR:  w_result = I_a_in ^ I_b_in;
            FN_NOR:  w_result = ~(I_a_in | I_b_in);
            default: w_result = 32'd0;
        endcase
    end

    assign w_zero = (w_result == 32'd0);

`ifdef C5_ALU_OUTPUT_REG_EN
    logic [31:0] r_c_alu;
    logic        r_zero;
    logic        r_overflow;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_c_alu    <= 32'd0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_c_alu    <= w_result;
            r_zero     <= w_zero;
            r_overflow <= w_overflow;
        end
    end

    assign O_c_alu    = r_c_alu;
    assign O_zero     = r_zero;
    assign O_overflow = r_overflow;
`else
    // Clock and reset have no load in the combinational build.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = I_clk ^ I_rst_n;

    assign O_c_alu    = w_result;
    assign O_zero     = w_zero;
    assign O_overflow = w_overflow;
`endif

endmodule

// File: tb/tb_c5_alu_unit.sv
// Directed, table-driven check of c5_alu_unit; works for both the combinational
// and the C5_ALU_OUTPUT_REG_EN build.
module tb_c5_alu_unit;

    logic        I_clk;
    logic        I_rst_n;
    logic [31:0] I_a_in;
    logic [31:0] I_b_in;
    logic [3:0]  I_alu_function;
    logic [31:0] O_c_alu;
    logic        O_zero;
    logic        O_overflow;

    int n_checks;
    int n_fail;

    c5_alu_unit dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_a_in         (I_a_in),
        .I_b_in         (I_b_in),
        .I_alu_function (I_alu_function),
        .O_c_alu        (O_c_alu),
        .O_zero         (O_zero),
        .O_overflow     (O_overflow)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [31:0] c;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one operation and wait until its result is visible on the outputs.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        I_a_in         = a;
        I_b_in         = b;
        I_alu_function = f;
`ifdef C5_ALU_OUTPUT_REG_EN
        @(posedge I_clk);
        #1;
`else
        #2;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        I_rst_n        = 1'b0;
        I_a_in         = 32'd0;
        I_b_in         = 32'd0;
        I_alu_function = 4'd0;

        // a, b, func, result, zero, overflow
        vecs.push_back('{32'd2,        32'd3, 4'd1, 32'd5,        1'b0, 1'b0});
        vecs.push_back('{32'd2,        32'd1, 4'd1, 32'd3,        1'b0, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd1, 32'd4,        1'b0, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd2, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd3, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd4, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd5, 32'd2,        1'b0, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd6, 32'd2,        1'b0, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd7, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd8, 32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{32'd2,        32'd2, 4'd0, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 4'd3, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 4'd4, 32'd1,        1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 4'd1, 32'd0,        1'b1, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'd1, 4'd1, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'd1, 4'd2, 32'h7FFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'd1, 4'd4, 32'd1,        1'b0, 1'b0});
        vecs.push_back('{32'd1,        32'd2, 4'd3, 32'd1,        1'b0, 1'b0});
        vecs.push_back('{32'd3,        32'd5, 4'd2, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 4'd4, 32'd0,    1'b1, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 4'd3, 32'd1,    1'b0, 1'b0});
        vecs.push_back('{32'hA5A5A5A5, 32'h0F0F0F0F, 4'd7, 32'hAAAAAAAA, 1'b0, 1'b0});
        vecs.push_back('{32'hA5A5A5A5, 32'h0F0F0F0F, 4'd9, 32'd0,    1'b1, 1'b0});
        vecs.push_back('{32'hA5A5A5A5, 32'h0F0F0F0F, 4'd15, 32'd0,   1'b1, 1'b0});

        // Reset state: registered build clears the outputs, combinational build sees func 0.
        #12;
        chk("reset c_alu",    O_c_alu,           32'd0);
        chk("reset zero",     {31'd0, O_zero},     32'd1);
        chk("reset overflow", {31'd0, O_overflow}, 32'd0);
        $display("reset: c=0x%08h z=%0b v=%0b", O_c_alu, O_zero, O_overflow);
        #1;
        I_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].f);
            chk($sformatf("vec%0d c_alu", i),    O_c_alu,                  vecs[i].c);
            chk($sformatf("vec%0d zero", i),     {31'd0, O_zero},          {31'd0, vecs[i].z});
            chk($sformatf("vec%0d overflow", i), {31'd0, O_overflow},      {31'd0, vecs[i].v});
            $display("vec%0d: a=0x%08h b=0x%08h f=%0d -> c=0x%08h z=%0b v=%0b",
                     i, vecs[i].a, vecs[i].b, vecs[i].f, O_c_alu, O_zero, O_overflow);
        end

`ifdef C5_ALU_OUTPUT_REG_EN
        // Input changes between edges must not reach the registered outputs.
        apply(32'd2, 32'd3, 4'd1);
        chk("pre-hold c_alu", O_c_alu, 32'd5);
        I_a_in = 32'h7FFFFFFF;
        I_b_in = 32'd1;
        #2;
        chk("hold c_alu", O_c_alu, 32'd5);
        $display("hold: c=0x%08h", O_c_alu);

        // Asynchronous reset with a different result in flight.
        I_rst_n = 1'b0;
        #1;
        chk("async rst c_alu",    O_c_alu,             32'd0);
        chk("async rst zero",     {31'd0, O_zero},     32'd1);
        chk("async rst overflow", {31'd0, O_overflow}, 32'd0);
        $display("async reset: c=0x%08h z=%0b v=%0b", O_c_alu, O_zero, O_overflow);
        @(posedge I_clk);
        #1;
        chk("rst held c_alu", O_c_alu,         32'd0);
        chk("rst held zero",  {31'd0, O_zero}, 32'd1);
        $display("reset held over edge: c=0x%08h z=%0b", O_c_alu, O_zero);

        I_rst_n = 1'b1;
        apply(32'd2, 32'd3, 4'd1);
        chk("post-rst c_alu", O_c_alu,         32'd5);
        chk("post-rst zero",  {31'd0, O_zero}, 32'd0);
        $display("post reset add: c=0x%08h", O_c_alu);
        apply(32'd2, 32'd3, 4'd15);
        chk("post-rst f15 c_alu", O_c_alu,         32'd0);
        chk("post-rst f15 zero",  {31'd0, O_zero}, 32'd1);
        $display("post reset func15: c=0x%08h z=%0b", O_c_alu, O_zero);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c5_alu_unit.md
# c5_alu_unit

32-bit integer ALU for the c5 MIPS-compatible core, in the execute stage between operand muxes and the writeback/branch logic. It performs add, subtract, unsigned/signed set-less-than and the four bitwise logic operations, selected by a 4-bit function code. Add, subtract and compare share one 32-bit adder/subtractor datapath. An optional output register, compiled in by macro, adds one cycle of latency.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- I_clk  input  1  system clock, rising edge active
- I_rst_n  input  1  reset, asynchronous, active-low
- I_a_in  input  32  operand A
- I_b_in  input  32  operand B
- I_alu_function  input  4  operation select (encoding in Operation)
- O_c_alu  output  32  result
- O_zero  output  1  high when O_c_alu == 0
- O_overflow  output  1  signed overflow of add/sub; 0 for all other functions

## Operation
- Function encoding (all other codes, 9–15, also produce 0):
  - 0 nothing: result 0
  - 1 add: A + B mod 2^32
  - 2 sub: A − B mod 2^32
  - 3 sltu: {31'b0, A < B unsigned}
  - 4 slt: {31'b0, A < B signed two's complement}
  - 5 or: A | B
  - 6 and: A & B
  - 7 xor: A ^ B
  - 8 nor: ~(A | B)
- Shared adder: sum = A + (do_add ? B : ~B) + (do_add ? 0 : 1), with 33-bit carry out. do_add = 1 only for function 1; functions 2, 3 and 4 subtract.
- sltu = NOT carry-out of the subtraction (borrow).
- slt = sum[31] XOR overflow.
- Overflow:
  - add: (A[31] == B[31]) && (sum[31] != A[31])
  - sub: (A[31] != B[31]) && (sum[31] != A[31])
  - forced 0 for functions other than 1 and 2.
- O_zero is derived from the final O_c_alu value, so it is 1 for function 0 and for unused codes.
- No exceptions are raised. Overflow is reported only; the result still wraps.

## Timing
- Without the register option:
  - Purely combinational from I_a_in, I_b_in, I_alu_function to all outputs, with zero latency.
  - I_clk and I_rst_n are unused.
- With the register option:
  - O_c_alu, O_zero and O_overflow are registered on the rising edge of I_clk, giving 1-cycle latency.
  - Operands and function are sampled every cycle; there is no enable or handshake.
- Reset (register option):
  - Asserting I_rst_n low immediately clears O_c_alu = 0, O_overflow = 0 and sets O_zero = 1.
  - Reset asserted mid-stream discards any in-flight result.
  - The first result after deassertion appears one edge after the first sampled inputs.
- Changing inputs between edges has no effect on registered outputs until the next edge.

## Configuration
- C5_ALU_OUTPUT_REG_EN
  - Defined: output register stage present, as described in Timing.
  - Undefined: fully combinational outputs with no state.
- Function encoding and arithmetic are identical in both builds.

## Test plan
- A=2, B=3, func=1 → O_c_alu=5. Then B=1 → 3. Then B=2 → 4; O_overflow=0.
- A=2, B=2: sweep the function code, with O_zero tracking each result:
  - func 2 → 0, O_zero=1
  - func 3 → 0; func 4 → 0
  - func 5 → 2; func 6 → 2
  - func 7 → 0; func 8 → 0xFFFFFFFD
  - func 0 → 0
- A=0xFFFFFFFF, B=1:
  - func 3 → 0
  - func 4 → 1
  - func 1 → 0, O_zero=1, O_overflow=0
- A=0x7FFFFFFF, B=1, func 1 → 0x80000000, O_overflow=1.
- A=0x80000000, B=1, func 2 → 0x7FFFFFFF, O_overflow=1. Same operands with func 4 → 1.
- Registered build:
  - Assert I_rst_n low mid-operation → outputs 0 / O_zero=1 immediately.
  - After release, apply A=2, B=3, func=1 → O_c_alu=5 one rising edge later.
  - func=15 → 0 on the next edge.
